// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings and
// the width helper used to size the settle down-counter.
package tts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } tts_state_e;

    // Bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (1 << i)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tts_order_gen.sv
// Sweep-order mapper: turns the binary sweep index into the vector driven to
// the DUT, either straight binary or reflected Gray code.
module tts_order_gen #(
    parameter int N_IN = 4,
    parameter bit GRAY = 1'b0
) (
    input  logic [N_IN-1:0] i_idx,
    output logic [N_IN-1:0] o_vec
);

    generate
        if (GRAY) begin : g_gray
            // Reflected Gray code: adjacent vectors differ in one input bit.
            always_comb begin
                o_vec = i_idx ^ (i_idx >> 1);
            end
        end else begin : g_bin
            // Binary ascending order.
            always_comb begin
                o_vec = i_idx;
            end
        end
    endgenerate

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for a small N-input, 1-output combinational
// block. Drives every input vector, holds it SETTLE cycles, then samples and
// compares the DUT output against EXP_TABLE (indexed by vector value).
//
// Optional build macro: TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
//   defined   -> the sweep ends at the first mismatch
//   undefined -> the full sweep always runs, counting every mismatch
//
// state  | meaning
// IDLE   | waiting for start, no results yet
// SETTLE | vector applied, settle down-counter running
// CHECK  | single cycle, DUT output sampled at its closing edge
// DONE   | results held until the next accepted start
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int                     N_IN      = 4,
    parameter int                     SETTLE    = 2,
    parameter logic [(1<<N_IN)-1:0]   EXP_TABLE = '0,
    parameter bit                     GRAY      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_f_i,
    output logic [N_IN-1:0] vec_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int             NVEC      = 1 << N_IN;
    localparam int             IDX_W     = N_IN + 1;
    // A SETTLE of 1 needs no counting, but keep at least one bit of register.
    localparam int             CNT_W     = (clog2(SETTLE) < 1) ? 1 : clog2(SETTLE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);
    localparam logic [N_IN:0]  ERR_MAX   = (N_IN + 1)'(NVEC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    tts_state_e        r_state;
    tts_state_e        w_state_nxt;
    logic [IDX_W-1:0]  r_index;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_IN:0]     r_err_count;
    logic [N_IN-1:0]   r_ffv;
    logic              r_ffvalid;

    logic [N_IN-1:0]   w_vec;
    logic              w_exp;
    logic              w_mismatch;
    logic              w_last;
    logic              w_stop;
    logic              w_cnt_tc;
    logic              w_start_ok;

    tts_order_gen #(
        .N_IN (N_IN),
        .GRAY (GRAY)
    ) u_order (
        .i_idx (r_index[N_IN-1:0]),
        .o_vec (w_vec)
    );

    assign w_exp      = EXP_TABLE[w_vec];
    // X or Z on the DUT output must never compare equal, hence the 4-state compare.
    assign w_mismatch = (dut_f_i !== w_exp);
    assign w_last     = (r_index == IDX_LAST);
    assign w_cnt_tc   = (r_cnt == '0);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_tc) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_last || w_stop) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sweep index, settle timer and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index     <= '0;
            r_cnt       <= '0;
            r_err_count <= '0;
            r_ffv       <= '0;
            r_ffvalid   <= 1'b0;
        end else if (w_start_ok) begin
            r_index     <= '0;
            r_cnt       <= CNT_LOAD;
            r_err_count <= '0;
            r_ffv       <= '0;
            r_ffvalid   <= 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (!w_cnt_tc) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != ERR_MAX) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                        if (!r_ffvalid) begin
                            r_ffv     <= w_vec;
                            r_ffvalid <= 1'b1;
                        end
                    end
                    // On the way to DONE the index stays put so vec_o holds the last vector.
                    if (!(w_last || w_stop)) begin
                        r_index <= r_index + 1'b1;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (r_state)
            ST_SETTLE, ST_CHECK: busy = 1'b1;
            ST_DONE: begin
                done = 1'b1;
                pass = (r_err_count == '0);
            end
            default: ;
        endcase
    end

    assign vec_o            = w_vec;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_ffv;
    assign first_fail_valid = r_ffvalid;

endmodule
